// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and encodings for pipe_stage_reg: occupancy states and IF/ID payload constants.
// Used by pipe_stage_reg and pipe_skid_buf; the PIPE_STAGE_PERF_EN macro is consumed by the top only.
package pipe_stage_reg_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;

  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  // Bubble payload for an IF/ID instance: zero PC, NOP instruction.
  localparam logic [PC_W+INST_W-1:0] IFID_NOP_VAL = {16'h0000, NOP_INST};

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input logic main_vld, input logic skid_vld);
    if (skid_vld)      return OCC_FULL;
    else if (main_vld) return OCC_ONE;
    else               return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry of the pipeline stage: one valid bit plus payload, driven by load/clear strobes.
// The payload is only meaningful while valid is set, so it is not reset.
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  output logic              skid_vld_p1,
  output logic [DATA_W-1:0] skid_data_p1
);

  // ---- stage p1: skid entry ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_p1 <= 1'b0;
    end else if (clear) begin
      skid_vld_p1 <= 1'b0;
    end else if (load) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !clear) begin
      skid_data_p1 <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, 2-entry skid and flush bubble.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/flush_cnt performance counters (and CNT_W).
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int              CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              skid_vld_p1;
  logic [DATA_W-1:0] skid_data_p1;
  logic              acc;
  logic              cons;
  logic              skid_load;
  logic              skid_clear;
  occ_e              occ;

  assign occ       = occ_of(vld_p1, skid_vld_p1);
  assign in_ready  = !skid_vld_p1;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;

  assign acc  = in_valid && in_ready;
  assign cons = vld_p1 && out_ready;

  // Skid only fills when main is held and a new beat arrives; it drains into main on cons.
  assign skid_load  = !flush && (occ == OCC_ONE) && acc && !cons;
  assign skid_clear = flush || ((occ == OCC_FULL) && cons);

  pipe_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .load        (skid_load),
    .clear       (skid_clear),
    .load_data   (in_data),
    .skid_vld_p1 (skid_vld_p1),
    .skid_data_p1(skid_data_p1)
  );

  // ---- stage p1: main entry ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= NOP_VAL;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      data_p1 <= NOP_VAL;
    end else begin
      unique case (occ)
        OCC_EMPTY: begin
          if (acc) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data;
          end
        end
        OCC_ONE: begin
          if (cons && acc) begin
            data_p1 <= in_data;
          end else if (cons) begin
            vld_p1  <= 1'b0;
            data_p1 <= NOP_VAL;
          end
        end
        OCC_FULL: begin
          if (cons) begin
            data_p1 <= skid_data_p1;
          end
        end
        default: begin
          vld_p1  <= vld_p1;
          data_p1 <= data_p1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic stall_evt;
  logic flush_evt;

  assign stall_evt = vld_p1 && !out_ready;
  assign flush_evt = flush && (vld_p1 || skid_vld_p1 || in_valid);

  // ---- stage p1: performance counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (DATA_W=32, NOP_VAL=0): directed vector table plus an occupancy scoreboard.
// Build with or without PIPE_STAGE_PERF_EN; counter checks follow the macro.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .NOP_VAL(32'h0)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W  (16)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ir;
    logic        ov;
    logic [31:0] od;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] q[$];
  int          exp_stall = 0;
  int          exp_flush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("sb_in_ready", {31'b0, in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
    chk("sb_out_valid", {31'b0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    chk("sb_out_data", out_data, (q.size() > 0) ? q[0] : 32'h0);
`ifdef PIPE_STAGE_PERF_EN
    chk("sb_stall_cnt", {16'b0, stall_cnt}, exp_stall);
    chk("sb_flush_cnt", {16'b0, flush_cnt}, exp_flush);
`endif
  endtask

  // Drive one cycle: check current state against the model, then advance model and clock.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic acc;
    logic cons;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    check_model();
    acc  = iv && (q.size() < 2);
    cons = ordy && (q.size() > 0);
    if (q.size() > 0 && !ordy && exp_stall < 65535) exp_stall++;
    if (fl && (q.size() > 0 || iv) && exp_flush < 65535) exp_flush++;
    if (cons) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'b0, flush_cnt}, 32'd0);
`endif
    #1;
    rst = 1'b0;
    q.delete();
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678};
    tbl[1]  = '{1'b1, 32'h1236_9ABC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1236_9ABC};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h1,         1'b0, 1'b0, 1'b1, 1'b1, 32'h1};
    tbl[4]  = '{1'b1, 32'h2,         1'b0, 1'b0, 1'b0, 1'b1, 32'h1};
    tbl[5]  = '{1'b1, 32'h3,         1'b0, 1'b0, 1'b0, 1'b1, 32'h1};
    tbl[6]  = '{1'b1, 32'h3,         1'b1, 1'b0, 1'b1, 1'b1, 32'h2};
    tbl[7]  = '{1'b1, 32'h3,         1'b1, 1'b0, 1'b1, 1'b1, 32'h3};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 32'hA,         1'b0, 1'b0, 1'b1, 1'b1, 32'hA};
    tbl[10] = '{1'b1, 32'hB,         1'b0, 1'b0, 1'b0, 1'b1, 32'hA};
    tbl[11] = '{1'b1, 32'h4321_8765, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 32'hAA,        1'b1, 1'b0, 1'b1, 1'b1, 32'hAA};
    tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0};

    do_reset();

    // Mid-stream reset with the stage FULL.
    step(1'b1, 32'hDEAD_0001, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_0002, 1'b0, 1'b0);
    chk("pre_rst_full", {31'b0, in_ready}, 32'd0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].ir});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
      if (i == 8) begin
`ifdef PIPE_STAGE_PERF_EN
        chk("bp_stall_cnt", {16'b0, stall_cnt}, 32'd2);
`endif
      end
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("tbl_stall_cnt", {16'b0, stall_cnt}, 32'd4);
    chk("tbl_flush_cnt", {16'b0, flush_cnt}, 32'd2);
`endif

    // Randomised valid/ready/flush against the scoreboard.
    for (int c = 0; c < 5000; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // Forced long stall to saturate stall_cnt.
    do_reset();
    step(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
    for (int c = 0; c < 65540; c++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_sat", {16'b0, stall_cnt}, 32'h0000_FFFF);
    chk("stall_hold_data", out_data, 32'h5A5A_5A5A);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_sat_after", {16'b0, stall_cnt}, 32'h0000_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
